// File: rtl/niosii_pipe_ctrl_if.sv
// niosII pipeline-control bundle: hazard inputs from ID/EX/MEM/WB
// and enable/bubble/forward/stall outputs back to the pipeline.
interface niosii_pipe_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs_a;
  logic [RA_W-1:0] id_rs_b;
  logic            id_use_a;
  logic            id_use_b;
  logic            ex_valid;
  logic [RA_W-1:0] ex_rd;
  logic            ex_wr;
  logic            ex_is_load;
  logic            ex_is_mul;
  logic            ex_br_taken;
  logic [RA_W-1:0] ex_rs_a;
  logic [RA_W-1:0] ex_rs_b;
  logic [RA_W-1:0] mem_rd;
  logic            mem_wr;
  logic [RA_W-1:0] wb_rd;
  logic            wb_wr;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             mul_busy;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
    output ex_valid, ex_rd, ex_wr, ex_is_load, ex_is_mul,
    output ex_br_taken, ex_rs_a, ex_rs_b,
    output mem_rd, mem_wr, wb_rd, wb_wr,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
    input  exmem_bubble, mul_busy, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
    input  ex_valid, ex_rd, ex_wr, ex_is_load, ex_is_mul,
    input  ex_br_taken, ex_rs_a, ex_rs_b,
    input  mem_rd, mem_wr, wb_rd, wb_wr,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble,
    output exmem_bubble, mul_busy, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/niosii_pipe_ctrl.sv
// niosII 5-stage sequencing: load-use stall, mul hold, branch flush,
// EX forwarding and saturating stall counter. Option macro: NIOS_FWD_EN.
// Ports: clk, rst (async, active-low), bus (niosii_pipe_ctrl_if.slave).
module niosii_pipe_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int RA_W        = 5,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  niosii_pipe_ctrl_if.slave bus
);
  localparam int MW   = $clog2(MUL_LATENCY + 1);
  localparam int HOLD = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
  localparam logic [MW-1:0] HOLD_INIT = MW'(HOLD);
  localparam logic MUL_ON = (MUL_LATENCY > 1);

  typedef enum logic {RUN, MUL} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    mcnt_q, mcnt_d;
  logic [CNT_W-1:0] scnt_q;

  logic [RA_W-1:0] id_a, id_b, ex_rd, mem_rd;
  logic            ua, ub, ld_use, id_stall, mul_go;
  logic            pc_en, ifid_en, ifid_flush, idex_en;
  logic            idex_bubble, exmem_bubble, mul_busy, hold;
  logic [1:0]      fwd_a, fwd_b;

  assign id_a   = bus.id_rs_a;
  assign id_b   = bus.id_rs_b;
  assign ex_rd  = bus.ex_rd;
  assign mem_rd = bus.mem_rd;
  assign ua     = bus.id_use_a & (id_a != '0);
  assign ub     = bus.id_use_b & (id_b != '0);

  function automatic logic id_hit(input logic [RA_W-1:0] rd);
    return (ua && id_a == rd) || (ub && id_b == rd);
  endfunction

  assign ld_use = bus.ex_valid & bus.ex_is_load & bus.ex_wr
                & (ex_rd != '0) & bus.id_valid & id_hit(ex_rd);
  assign mul_go = bus.ex_valid & bus.ex_is_mul & MUL_ON;

`ifdef NIOS_FWD_EN
  logic [RA_W-1:0] wb_rd, ex_a, ex_b;
  assign wb_rd = bus.wb_rd;
  assign ex_a  = bus.ex_rs_a;
  assign ex_b  = bus.ex_rs_b;

  // MEM holds the younger result, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
    if (rs == '0) return 2'b00;
    if (bus.mem_wr && mem_rd == rs) return 2'b01;
    if (bus.wb_wr && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  assign id_stall = ld_use;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  assign fwd_a_raw = fwd_sel(ex_a);
  assign fwd_b_raw = fwd_sel(ex_b);
`else
  logic raw_ex, raw_mem;
  // WB writes before the regfile read, so only EX/MEM producers stall.
  assign raw_ex  = bus.ex_wr & (ex_rd != '0) & id_hit(ex_rd);
  assign raw_mem = bus.mem_wr & (mem_rd != '0) & id_hit(mem_rd);
  assign id_stall = ld_use | (bus.id_valid & (raw_ex | raw_mem));
  logic [1:0] fwd_a_raw, fwd_b_raw;
  assign fwd_a_raw = 2'b00;
  assign fwd_b_raw = 2'b00;
  logic unused_fwd;
  assign unused_fwd = ^{bus.ex_rs_a, bus.ex_rs_b, bus.wb_rd, bus.wb_wr};
`endif

  always_comb begin
    state_d      = state_q;
    mcnt_d       = mcnt_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mul_busy     = 1'b0;
    hold         = 1'b0;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;
    unique case (state_q)
      RUN: begin
        if (mul_go) begin
          hold    = 1'b1;
          mcnt_d  = HOLD_INIT;
          state_d = MUL;
        end else if (bus.ex_br_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_stall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MUL: begin
        if (mcnt_q != '0) begin
          hold   = 1'b1;
          mcnt_d = mcnt_q - MW'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (hold) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_bubble = 1'b1;
      mul_busy     = 1'b1;
    end
    // Reset takes effect on outputs in the same cycle.
    if (!rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      mul_busy     = 1'b0;
      fwd_a        = 2'b00;
      fwd_b        = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      mcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      if (!pc_en && scnt_q != '1)
        scnt_q <= scnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_en      = idex_en;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_bubble = exmem_bubble;
  assign bus.mul_busy     = mul_busy;
  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;
  assign bus.stall_cnt    = scnt_q;
endmodule

// File: tb/tb_niosii_pipe_ctrl.sv
// Directed bench for niosii_pipe_ctrl: reset, load-use, mul hold,
// branch flush, forwarding / no-forward stalls, mid-mul reset, loop.
module tb_niosii_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  niosii_pipe_ctrl_if #(.RA_W(5), .CNT_W(16)) b ();

  niosii_pipe_ctrl #(
    .MUL_LATENCY(3), .RA_W(5), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  task automatic idle();
    b.id_valid = 0; b.id_rs_a = 0; b.id_rs_b = 0;
    b.id_use_a = 0; b.id_use_b = 0;
    b.ex_valid = 0; b.ex_rd = 0; b.ex_wr = 0;
    b.ex_is_load = 0; b.ex_is_mul = 0; b.ex_br_taken = 0;
    b.ex_rs_a = 0; b.ex_rs_b = 0;
    b.mem_rd = 0; b.mem_wr = 0; b.wb_rd = 0; b.wb_wr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld_use();
    b.ex_valid = 1; b.ex_is_load = 1; b.ex_wr = 1; b.ex_rd = 7;
    b.id_valid = 1; b.id_use_b = 1; b.id_rs_b = 7;
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk);
    total++; if (b.pc_en !== 1'b0) begin bad++; $display("FAIL rst_pc got=%0b want=0", b.pc_en); end
    total++; if (b.idex_bubble !== 1'b1 || b.exmem_bubble !== 1'b1) begin bad++; $display("FAIL rst_bub got=%0b%0b want=11", b.idex_bubble, b.exmem_bubble); end
    total++; if (b.ifid_flush !== 1'b0 || b.mul_busy !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0b%0b want=00", b.ifid_flush, b.mul_busy); end
    total++; if (b.stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", b.stall_cnt); end
    step();
    rst = 1;
    @(negedge clk);
    total++; if ({b.pc_en, b.ifid_en, b.idex_en} !== 3'b111) begin bad++; $display("FAIL run_en got=%b want=111", {b.pc_en, b.ifid_en, b.idex_en}); end
    total++; if ({b.ifid_flush, b.idex_bubble, b.exmem_bubble, b.mul_busy} !== 4'b0000) begin bad++; $display("FAIL run_bub got=%b want=0000", {b.ifid_flush, b.idex_bubble, b.exmem_bubble, b.mul_busy}); end
  endtask

  task automatic test_load_use();
    step(); idle(); set_ld_use();
    @(negedge clk);
    total++; if ({b.pc_en, b.ifid_en, b.idex_bubble} !== 3'b001) begin bad++; $display("FAIL lu_stall got=%b want=001", {b.pc_en, b.ifid_en, b.idex_bubble}); end
    exp_cnt++;
    step(); idle();
    @(negedge clk);
    total++; if (b.pc_en !== 1'b1) begin bad++; $display("FAIL lu_release got=%0b want=1", b.pc_en); end
    total++; if (b.stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_cnt got=%0d want=%0d", b.stall_cnt, exp_cnt); end
    step(); idle(); set_ld_use(); b.id_use_b = 0;
    @(negedge clk);
    total++; if (b.pc_en !== 1'b1) begin bad++; $display("FAIL lu_unused got=%0b want=1", b.pc_en); end
    step(); idle(); set_ld_use(); b.ex_rd = 0; b.id_rs_b = 0;
    @(negedge clk);
    total++; if (b.pc_en !== 1'b1) begin bad++; $display("FAIL lu_r0 got=%0b want=1", b.pc_en); end
    step(); idle();
  endtask

  task automatic test_mul();
    step(); idle(); b.ex_valid = 1; b.ex_is_mul = 1;
    @(negedge clk);
    total++; if ({b.mul_busy, b.pc_en, b.idex_en, b.exmem_bubble} !== 4'b1001) begin bad++; $display("FAIL mul_t got=%b want=1001", {b.mul_busy, b.pc_en, b.idex_en, b.exmem_bubble}); end
    exp_cnt++;
    step(); b.ex_br_taken = 1;
    @(negedge clk);
    total++; if ({b.mul_busy, b.pc_en, b.exmem_bubble, b.ifid_flush} !== 4'b1010) begin bad++; $display("FAIL mul_t1 got=%b want=1010", {b.mul_busy, b.pc_en, b.exmem_bubble, b.ifid_flush}); end
    exp_cnt++;
    step(); b.ex_br_taken = 0;
    @(negedge clk);
    total++; if ({b.mul_busy, b.pc_en, b.exmem_bubble} !== 3'b010) begin bad++; $display("FAIL mul_t2 got=%b want=010", {b.mul_busy, b.pc_en, b.exmem_bubble}); end
    total++; if (b.stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL mul_cnt got=%0d want=%0d", b.stall_cnt, exp_cnt); end
    step(); idle();
    @(negedge clk);
    total++; if (b.pc_en !== 1'b1 || b.mul_busy !== 1'b0) begin bad++; $display("FAIL mul_after got=%0b%0b want=10", b.pc_en, b.mul_busy); end
  endtask

  task automatic test_branch();
    step(); idle(); set_ld_use(); b.ex_br_taken = 1;
    @(negedge clk);
    total++; if ({b.ifid_flush, b.idex_bubble, b.pc_en} !== 3'b111) begin bad++; $display("FAIL br_flush got=%b want=111", {b.ifid_flush, b.idex_bubble, b.pc_en}); end
    step(); idle();
    @(negedge clk);
    total++; if (b.stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL br_cnt got=%0d want=%0d", b.stall_cnt, exp_cnt); end
    total++; if (b.ifid_flush !== 1'b0) begin bad++; $display("FAIL br_once got=%0b want=0", b.ifid_flush); end
  endtask

  task automatic test_fwd();
`ifdef NIOS_FWD_EN
    step(); idle();
    b.mem_rd = 5; b.mem_wr = 1; b.wb_rd = 5; b.wb_wr = 1; b.ex_rs_a = 5; b.ex_rs_b = 3;
    b.id_valid = 1; b.id_use_a = 1; b.id_rs_a = 5;
    @(negedge clk);
    total++; if (b.fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_mem got=%b want=01", b.fwd_a); end
    total++; if (b.fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_nob got=%b want=00", b.fwd_b); end
    total++; if (b.pc_en !== 1'b1) begin bad++; $display("FAIL fwd_nostall got=%0b want=1", b.pc_en); end
    step(); b.mem_wr = 0; b.ex_rs_b = 5;
    @(negedge clk);
    total++; if (b.fwd_a !== 2'b10 || b.fwd_b !== 2'b10) begin bad++; $display("FAIL fwd_wb got=%b%b want=1010", b.fwd_a, b.fwd_b); end
    step(); b.mem_wr = 1; b.ex_rs_a = 0; b.mem_rd = 0; b.wb_rd = 0;
    @(negedge clk);
    total++; if (b.fwd_a !== 2'b00 || b.fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_r0 got=%b%b want=0000", b.fwd_a, b.fwd_b); end
`else
    step(); idle();
    b.mem_rd = 5; b.mem_wr = 1; b.ex_rs_a = 5;
    b.id_valid = 1; b.id_use_a = 1; b.id_rs_a = 5;
    @(negedge clk);
    total++; if (b.pc_en !== 1'b0 || b.idex_bubble !== 1'b1) begin bad++; $display("FAIL nf_mem got=%0b%0b want=01", b.pc_en, b.idex_bubble); end
    total++; if (b.fwd_a !== 2'b00) begin bad++; $display("FAIL nf_fwd got=%b want=00", b.fwd_a); end
    exp_cnt++;
    step(); b.mem_wr = 0; b.wb_rd = 5; b.wb_wr = 1;
    @(negedge clk);
    total++; if (b.pc_en !== 1'b1) begin bad++; $display("FAIL nf_wb got=%0b want=1", b.pc_en); end
    step(); b.wb_wr = 0; b.ex_valid = 1; b.ex_wr = 1; b.ex_rd = 5;
    @(negedge clk);
    total++; if (b.pc_en !== 1'b0) begin bad++; $display("FAIL nf_ex got=%0b want=0", b.pc_en); end
    exp_cnt++;
    step(); b.id_rs_a = 0; b.ex_rd = 0;
    @(negedge clk);
    total++; if (b.pc_en !== 1'b1) begin bad++; $display("FAIL nf_r0 got=%0b want=1", b.pc_en); end
`endif
    step(); idle();
    @(negedge clk);
    total++; if (b.stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL fwd_cnt got=%0d want=%0d", b.stall_cnt, exp_cnt); end
  endtask

  task automatic test_rst_mul();
    step(); idle(); b.ex_valid = 1; b.ex_is_mul = 1;
    step();
    rst = 0;
    exp_cnt = 0;
    @(negedge clk);
    total++; if ({b.pc_en, b.mul_busy, b.idex_bubble, b.exmem_bubble} !== 4'b0011) begin bad++; $display("FAIL rm_out got=%b want=0011", {b.pc_en, b.mul_busy, b.idex_bubble, b.exmem_bubble}); end
    total++; if (b.stall_cnt !== 16'd0) begin bad++; $display("FAIL rm_cnt0 got=%0d want=0", b.stall_cnt); end
    step(); idle();
    step();
    rst = 1;
    @(negedge clk);
    total++; if (b.pc_en !== 1'b1 || b.mul_busy !== 1'b0) begin bad++; $display("FAIL rm_resume got=%0b%0b want=10", b.pc_en, b.mul_busy); end
    step();
    @(negedge clk);
    total++; if (b.stall_cnt !== 16'd0) begin bad++; $display("FAIL rm_cnt got=%0d want=0", b.stall_cnt); end
  endtask

  task automatic test_loop();
    for (int i = 0; i < 6; i++) begin
      step(); idle(); set_ld_use(); exp_cnt++;
      step(); idle();
      step(); b.ex_valid = 1; b.ex_is_mul = 1; exp_cnt++;
      step(); exp_cnt++;
      step();
      step(); idle();
`ifndef NIOS_FWD_EN
      step(); b.mem_wr = 1; b.mem_rd = 9; b.id_valid = 1; b.id_use_a = 1; b.id_rs_a = 9; exp_cnt++;
      step(); idle();
`endif
      @(negedge clk);
      total++; if (b.stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL loop_cnt i=%0d got=%0d want=%0d", i, b.stall_cnt, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul();
    test_branch();
    test_fwd();
    test_rst_mul();
    test_loop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
